instr_sequencer: RTL

- Hardwired control sequencer for the 32-bit bus-based CPU datapath; sits directly upstream of the datapath top.
- Watches the IR contents and drives every datapath strobe each cycle: fetch, decode, execute and writeback.
- Also handles stop/run and halt handshaking with the board.
- All opcodes, ALU codes and per-instruction T-step sequences are fixed by this spec.

---
 rtl/cpu_defs.sv | 78 +++++++
 rtl/op_to_alu.sv | 29 ++
 rtl/instr_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the hardwired CPU control path: opcodes, ALU codes,
// sequencer state encoding, the strobe bundle and the per-opcode last T-step.
package cpu_defs;

    localparam int OPW   = 5;
    localparam int STEPW = 3;

    localparam logic [OPW-1:0] OP_LD   = 5'd0;
    localparam logic [OPW-1:0] OP_LDI  = 5'd1;
    localparam logic [OPW-1:0] OP_ST   = 5'd2;
    localparam logic [OPW-1:0] OP_ADD  = 5'd3;
    localparam logic [OPW-1:0] OP_SUB  = 5'd4;
    localparam logic [OPW-1:0] OP_AND  = 5'd5;
    localparam logic [OPW-1:0] OP_OR   = 5'd6;
    localparam logic [OPW-1:0] OP_ROR  = 5'd7;
    localparam logic [OPW-1:0] OP_ROL  = 5'd8;
    localparam logic [OPW-1:0] OP_SHR  = 5'd9;
    localparam logic [OPW-1:0] OP_SHRA = 5'd10;
    localparam logic [OPW-1:0] OP_SHL  = 5'd11;
    localparam logic [OPW-1:0] OP_ADDI = 5'd12;
    localparam logic [OPW-1:0] OP_ANDI = 5'd13;
    localparam logic [OPW-1:0] OP_ORI  = 5'd14;
    localparam logic [OPW-1:0] OP_DIV  = 5'd15;
    localparam logic [OPW-1:0] OP_MUL  = 5'd16;
    localparam logic [OPW-1:0] OP_NEG  = 5'd17;
    localparam logic [OPW-1:0] OP_NOT  = 5'd18;
    localparam logic [OPW-1:0] OP_BR   = 5'd19;
    localparam logic [OPW-1:0] OP_JR   = 5'd20;
    localparam logic [OPW-1:0] OP_JAL  = 5'd21;
    localparam logic [OPW-1:0] OP_IN   = 5'd22;
    localparam logic [OPW-1:0] OP_OUT  = 5'd23;
    localparam logic [OPW-1:0] OP_MFHI = 5'd24;
    localparam logic [OPW-1:0] OP_MFLO = 5'd25;
    localparam logic [OPW-1:0] OP_NOP  = 5'd26;
    localparam logic [OPW-1:0] OP_HALT = 5'd27;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_ROR  = 4'd4;
    localparam logic [3:0] ALU_ROL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SHRA = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXEC    = 2'd1,
        S_STOPPED = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    typedef struct packed {
        logic rin, rout, gra, grb, grc, baout, cout;
        logic pcin, pcout, incpc, irin, marin, mdrin, mdrout, mdrread, memwrite;
        logic yin, zin, zlowout, zhighout, hiin, hiout, loin, loout;
        logic conin, conout, inportout, outportin, r15ctrl;
    } strobes_t;

    // Final T-step of each instruction; undefined opcodes behave as nop.
    function automatic logic [STEPW-1:0] last_step(input logic [OPW-1:0] op);
        case (op)
            OP_LD, OP_ST:                                  last_step = 3'd7;
            OP_MUL, OP_DIV, OP_BR:                         last_step = 3'd6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL, OP_ADDI,
            OP_ANDI, OP_ORI:                               last_step = 3'd5;
            OP_NEG, OP_NOT, OP_JAL:                        last_step = 3'd4;
            default:                                       last_step = 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/op_to_alu.sv
// Combinational map from opcode to the ALU operation code.
module op_to_alu
    import cpu_defs::*;
(
    input  logic [OPW-1:0] op,
    output logic [3:0]     alu
);

    // Immediate forms share the ALU code of their register forms.
    always_comb begin
        alu = ALU_ADD;
        case (op)
            OP_SUB:          alu = ALU_SUB;
            OP_AND, OP_ANDI: alu = ALU_AND;
            OP_OR, OP_ORI:   alu = ALU_OR;
            OP_ROR:          alu = ALU_ROR;
            OP_ROL:          alu = ALU_ROL;
            OP_SHR:          alu = ALU_SHR;
            OP_SHRA:         alu = ALU_SHRA;
            OP_SHL:          alu = ALU_SHL;
            OP_MUL:          alu = ALU_MUL;
            OP_DIV:          alu = ALU_DIV;
            OP_NEG:          alu = ALU_NEG;
            OP_NOT:          alu = ALU_NOT;
            default:         alu = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Hardwired control sequencer: steps fetch/execute T-states and decodes the
// datapath strobes (Moore) from state, step and the IR opcode.
// Board handshake: stp is a level request looked at only on the edge that
// would start a new fetch; Run=0 acknowledges that the sequencer is parked
// (stopped or halted) and no strobes are issued while it is low.
module instr_sequencer
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IRdata,
    input  logic        stp,
    output logic        Rin,
    output logic        Rout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        BAout,
    output logic        Cout,
    output logic        PCin,
    output logic        PCout,
    output logic        IncPC,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDRread,
    output logic        memWrite,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        conIn,
    output logic        conOut,
    output logic        InPortout,
    output logic        outPortin,
    output logic        R15ctrl,
    output logic [3:0]  ALUselect,
    output logic        clr,
    output logic        Run,
    output logic        illegal,
    output logic [1:0]  dbg_state
);

    state_t           state, next_state;
    logic [STEPW-1:0] step, next_step;
    logic [OPW-1:0]   op;
    logic [3:0]       op_alu;
    logic             is_imm;
    strobes_t         strb;
    logic [3:0]       alu_sel;
    logic             ill;
    logic             unused_irdata;

    assign op            = IRdata[31:27];
    assign unused_irdata = ^IRdata[26:0];
    assign is_imm        = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);

    op_to_alu u_op_to_alu (
        .op  (op),
        .alu (op_alu)
    );

    // State and step registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            step  <= '0;
        end else begin
            state <= next_state;
            step  <= next_step;
        end
    end

    // Next state: fetch T0..T2, execute to the opcode's last step, then park or refetch.
    always_comb begin
        next_state = state;
        next_step  = step;
        case (state)
            S_FETCH: begin
                if (step == 3'd2) begin
                    next_state = S_EXEC;
                    next_step  = 3'd3;
                end else begin
                    next_step = step + 3'd1;
                end
            end
            S_EXEC: begin
                if (step == last_step(op)) begin
                    next_step = '0;
                    if (op == OP_HALT)
                        next_state = S_HALTED;
                    else if (stp)
                        next_state = S_STOPPED;
                    else
                        next_state = S_FETCH;
                end else begin
                    next_step = step + 3'd1;
                end
            end
            S_STOPPED: begin
                if (!stp)
                    next_state = S_FETCH;
            end
            S_HALTED: begin
                next_state = S_HALTED;
            end
        endcase
    end

    // Strobe decode; everything is forced quiet while reset is held low.
    always_comb begin
        strb    = '0;
        alu_sel = ALU_ADD;
        ill     = 1'b0;
        if (state == S_FETCH) begin
            case (step)
                3'd0:    begin strb.pcout = 1'b1; strb.marin = 1'b1; strb.incpc = 1'b1; end
                3'd1:    begin strb.mdrread = 1'b1; strb.mdrin = 1'b1; end
                3'd2:    begin strb.mdrout = 1'b1; strb.irin = 1'b1; end
                default: ;
            endcase
        end else if (state == S_EXEC) begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
                OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
                    case (step)
                        3'd3: begin strb.grb = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1; end
                        3'd4: begin
                            strb.zin = 1'b1;
                            alu_sel  = op_alu;
                            if (is_imm) begin
                                strb.cout = 1'b1;
                            end else begin
                                strb.grc  = 1'b1;
                                strb.rout = 1'b1;
                            end
                        end
                        3'd5:    begin strb.zlowout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
                        default: ;
                    endcase
                end
                OP_NEG, OP_NOT: begin
                    case (step)
                        3'd3:    begin strb.grb = 1'b1; strb.rout = 1'b1; strb.zin = 1'b1; alu_sel = op_alu; end
                        3'd4:    begin strb.zlowout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
                        default: ;
                    endcase
                end
                OP_MUL, OP_DIV: begin
                    case (step)
                        3'd3:    begin strb.gra = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1; end
                        3'd4:    begin strb.grb = 1'b1; strb.rout = 1'b1; strb.zin = 1'b1; alu_sel = op_alu; end
                        3'd5:    begin strb.zlowout = 1'b1; strb.loin = 1'b1; end
                        3'd6:    begin strb.zhighout = 1'b1; strb.hiin = 1'b1; end
                        default: ;
                    endcase
                end
                OP_LD, OP_LDI, OP_ST: begin
                    case (step)
                        3'd3: begin strb.grb = 1'b1; strb.rout = 1'b1; strb.baout = 1'b1; strb.yin = 1'b1; end
                        3'd4: begin strb.cout = 1'b1; strb.zin = 1'b1; end
                        3'd5: begin
                            strb.zlowout = 1'b1;
                            if (op == OP_LDI) begin
                                strb.gra = 1'b1;
                                strb.rin = 1'b1;
                            end else begin
                                strb.marin = 1'b1;
                            end
                        end
                        3'd6: begin
                            strb.mdrin = 1'b1;
                            if (op == OP_ST) begin
                                strb.gra  = 1'b1;
                                strb.rout = 1'b1;
                            end else begin
                                strb.mdrread = 1'b1;
                            end
                        end
                        3'd7: begin
                            if (op == OP_ST) begin
                                strb.memwrite = 1'b1;
                            end else begin
                                strb.mdrout = 1'b1;
                                strb.gra    = 1'b1;
                                strb.rin    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                OP_BR: begin
                    case (step)
                        3'd3:    begin strb.gra = 1'b1; strb.rout = 1'b1; strb.conin = 1'b1; end
                        3'd4:    begin strb.pcout = 1'b1; strb.yin = 1'b1; end
                        3'd5:    begin strb.cout = 1'b1; strb.zin = 1'b1; end
                        3'd6:    begin strb.zlowout = 1'b1; strb.conout = 1'b1; end
                        default: ;
                    endcase
                end
                OP_JR: begin
                    if (step == 3'd3) begin strb.gra = 1'b1; strb.rout = 1'b1; strb.pcin = 1'b1; end
                end
                OP_JAL: begin
                    case (step)
                        3'd3:    begin strb.pcout = 1'b1; strb.r15ctrl = 1'b1; end
                        3'd4:    begin strb.gra = 1'b1; strb.rout = 1'b1; strb.pcin = 1'b1; end
                        default: ;
                    endcase
                end
                OP_IN:   if (step == 3'd3) begin strb.inportout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
                OP_OUT:  if (step == 3'd3) begin strb.gra = 1'b1; strb.rout = 1'b1; strb.outportin = 1'b1; end
                OP_MFHI: if (step == 3'd3) begin strb.hiout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
                OP_MFLO: if (step == 3'd3) begin strb.loout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
                OP_NOP, OP_HALT: ;
                default: ill = (step == 3'd3);
            endcase
        end
        if (!reset) begin
            strb    = '0;
            alu_sel = ALU_ADD;
            ill     = 1'b0;
        end
    end

    assign Run       = !((state == S_STOPPED) || (state == S_HALTED) ||
                         ((state == S_EXEC) && (op == OP_HALT)));
    assign clr       = ~reset;
    assign illegal   = ill;
    assign ALUselect = alu_sel;
    assign dbg_state = state;

    assign Rin       = strb.rin;
    assign Rout      = strb.rout;
    assign Gra       = strb.gra;
    assign Grb       = strb.grb;
    assign Grc       = strb.grc;
    assign BAout     = strb.baout;
    assign Cout      = strb.cout;
    assign PCin      = strb.pcin;
    assign PCout     = strb.pcout;
    assign IncPC     = strb.incpc;
    assign IRin      = strb.irin;
    assign MARin     = strb.marin;
    assign MDRin     = strb.mdrin;
    assign MDRout    = strb.mdrout;
    assign MDRread   = strb.mdrread;
    assign memWrite  = strb.memwrite;
    assign Yin       = strb.yin;
    assign Zin       = strb.zin;
    assign ZLowout   = strb.zlowout;
    assign ZHighout  = strb.zhighout;
    assign HIin      = strb.hiin;
    assign HIout     = strb.hiout;
    assign LOin      = strb.loin;
    assign LOout     = strb.loout;
    assign conIn     = strb.conin;
    assign conOut    = strb.conout;
    assign InPortout = strb.inportout;
    assign outPortin = strb.outportin;
    assign R15ctrl   = strb.r15ctrl;

endmodule
